// File: rtl/branch_pkg.sv
// Shared types and constants for the EX-stage branch resolution slice.
package branch_pkg;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd4,
    BGE  = 3'd5,
    BLTU = 3'd6,
    BGEU = 3'd7
  } br_funct3_e;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } br_state_e;

  // funct3 values 010 and 011 have no conditional-branch meaning.
  function automatic logic funct3_legal(input logic [2:0] funct3);
    logic legal;
    case (funct3)
      3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of the six conditional-branch conditions.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            legal
);

  logic eq;
  logic lt_s;
  logic lt_u;

  // Equality by XOR-reduce; the GE forms reuse the LT comparators inverted.
  always_comb begin
    eq    = ~|(rs1 ^ rs2);
    lt_s  = $signed(rs1) < $signed(rs2);
    lt_u  = rs1 < rs2;
    legal = funct3_legal(funct3);
    case (funct3)
      BEQ:     taken = eq;
      BNE:     taken = ~eq;
      BLT:     taken = lt_s;
      BGE:     taken = ~lt_s;
      BLTU:    taken = lt_u;
      BGEU:    taken = ~lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: direction/target check, one-cycle flush with
// wrong-path squash, and saturating branch/mispredict statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_stall,
  input  logic [INST_WIDTH-1:0] ex_ir,
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic [ADDR_WIDTH-1:0] ex_target,
  input  logic [XLEN-1:0]       r_data_0,
  input  logic [XLEN-1:0]       r_data_1,
  input  logic                  ex_pred_taken,
  input  logic [ADDR_WIDTH-1:0] ex_pred_target,
  input  logic                  cnt_clear,
  output logic                  resolve_valid,
  output logic                  branch_taken,
  output logic                  mispredict_flag,
  output logic                  flush_req,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [CNT_WIDTH-1:0]  branch_cnt,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(3'd4);

  br_state_e             state_q, state_d;
  logic                  resolve_valid_q, resolve_valid_d;
  logic                  branch_taken_q, branch_taken_d;
  logic                  mispredict_q, mispredict_d;
  logic                  flush_q, flush_d;
  logic [ADDR_WIDTH-1:0] redirect_q, redirect_d;
  logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]  mispredict_cnt_q, mispredict_cnt_d;

  logic cond_taken;
  logic cond_legal;
  logic accept;
  logic mispredict;
  logic ir_unused;

  // Only opcode and funct3 matter here; the remaining fields are ignored.
  assign ir_unused = ^{ex_ir[INST_WIDTH-1:15], ex_ir[11:7]};

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .funct3 (ex_ir[14:12]),
    .rs1    (r_data_0),
    .rs2    (r_data_1),
    .taken  (cond_taken),
    .legal  (cond_legal)
  );

  // Next-state, output and counter computation.
  always_comb begin
    accept = ex_valid & ~ex_stall & (ex_ir[6:0] == OPCODE_BRANCH) &
             cond_legal & (state_q == RUN);
    mispredict = (cond_taken != ex_pred_taken) |
                 (cond_taken & ex_pred_taken & (ex_target != ex_pred_target));

    resolve_valid_d = accept;
    mispredict_d    = accept & mispredict;
    flush_d         = accept & mispredict;
    if (accept) begin
      branch_taken_d = cond_taken;
      redirect_d     = cond_taken ? ex_target : (ex_pc + PC_STEP);
    end else begin
      branch_taken_d = branch_taken_q;
      redirect_d     = redirect_q;
    end

    // The instruction behind a redirect is wrong-path and must not resolve.
    case (state_q)
      RUN:     state_d = (accept & mispredict) ? SQUASH : RUN;
      SQUASH:  state_d = RUN;
      default: state_d = RUN;
    endcase

    if (cnt_clear) begin
      branch_cnt_d     = '0;
      mispredict_cnt_d = '0;
    end else begin
      branch_cnt_d     = (accept && branch_cnt_q != CNT_MAX) ?
                         branch_cnt_q + CNT_ONE : branch_cnt_q;
      mispredict_cnt_d = (accept && mispredict && mispredict_cnt_q != CNT_MAX) ?
                         mispredict_cnt_q + CNT_ONE : mispredict_cnt_q;
    end
  end

  // State, registered outputs and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      resolve_valid_q  <= 1'b0;
      branch_taken_q   <= 1'b0;
      mispredict_q     <= 1'b0;
      flush_q          <= 1'b0;
      redirect_q       <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      resolve_valid_q  <= resolve_valid_d;
      branch_taken_q   <= branch_taken_d;
      mispredict_q     <= mispredict_d;
      flush_q          <= flush_d;
      redirect_q       <= redirect_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign resolve_valid   = resolve_valid_q;
  assign branch_taken    = branch_taken_q;
  assign mispredict_flag = mispredict_q;
  assign flush_req       = flush_q;
  assign redirect_pc     = redirect_q;
  assign branch_cnt      = branch_cnt_q;
  assign mispredict_cnt  = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed cases plus random traffic
// checked against a behavioural model; narrow counters make saturation reachable.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, ex_valid, ex_stall, ex_pred_taken, cnt_clear;
  logic [31:0]   ex_ir, ex_pc, ex_target, r_data_0, r_data_1, ex_pred_target;
  logic          resolve_valid, branch_taken, mispredict_flag, flush_req;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] branch_cnt, mispredict_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .INST_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_ir(ex_ir),
    .ex_pc(ex_pc), .ex_target(ex_target), .r_data_0(r_data_0), .r_data_1(r_data_1),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .cnt_clear(cnt_clear),
    .resolve_valid(resolve_valid), .branch_taken(branch_taken),
    .mispredict_flag(mispredict_flag), .flush_req(flush_req), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  typedef struct {
    logic        taken;
    logic        mis;
    logic [31:0] red;
  } exp_t;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [CW-1:0] m_bcnt = '0;
  logic [CW-1:0] m_mcnt = '0;
  logic          m_squash = 1'b0;
  logic          m_taken = 1'b0;
  logic [31:0]   m_red = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [6:0] opc);
    return {17'd0, f3, 5'd0, opc};
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle of inputs, then advance the model across the edge.
  task automatic step(input logic v, input logic st, input logic [31:0] ir, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic [31:0] a, input logic [31:0] b,
                      input logic pt, input logic [31:0] ptg, input logic clr, input logic r);
    logic acc, act, mis;
    logic [2:0] f3;
    rst = r; ex_valid = v; ex_stall = st; ex_ir = ir; ex_pc = pc; ex_target = tgt;
    r_data_0 = a; r_data_1 = b; ex_pred_taken = pt; ex_pred_target = ptg; cnt_clear = clr;
    f3  = ir[14:12];
    act = ref_taken(f3, a, b);
    acc = v && !st && ir[6:0] == 7'b1100011 && f3 != 3'd2 && f3 != 3'd3 && !m_squash;
    mis = (act != pt) || (act && pt && tgt != ptg);
    @(posedge clk);
    if (r) begin
      m_bcnt = '0; m_mcnt = '0; m_squash = 1'b0; m_taken = 1'b0; m_red = 32'd0;
      sb_q.delete();
    end else begin
      if (acc) begin
        m_taken = act;
        m_red   = act ? tgt : pc + 32'd4;
        sb_q.push_back('{taken: act, mis: mis, red: m_red});
      end
      if (clr) begin
        m_bcnt = '0; m_mcnt = '0;
      end else begin
        if (acc && m_bcnt != {CW{1'b1}}) m_bcnt = m_bcnt + 1'b1;
        if (acc && mis && m_mcnt != {CW{1'b1}}) m_mcnt = m_mcnt + 1'b1;
      end
      m_squash = acc && mis;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a resolution.
  always @(negedge clk) begin
    exp_t e;
    if (resolve_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_resolve", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("taken", {31'd0, branch_taken}, {31'd0, e.taken});
        chk("mispredict_flag", {31'd0, mispredict_flag}, {31'd0, e.mis});
        chk("flush_req", {31'd0, flush_req}, {31'd0, e.mis});
        chk("redirect_pc", redirect_pc, e.red);
      end
    end else begin
      chk("missing_resolve", sb_q.size(), 32'd0);
      chk("idle_flush", {31'd0, flush_req}, 32'd0);
      chk("idle_mispredict", {31'd0, mispredict_flag}, 32'd0);
    end
    chk("branch_cnt", {28'd0, branch_cnt}, {28'd0, m_bcnt});
    chk("mispredict_cnt", {28'd0, mispredict_cnt}, {28'd0, m_mcnt});
    chk("hold_taken", {31'd0, branch_taken}, {31'd0, m_taken});
    chk("hold_redirect", redirect_pc, m_red);
  end

  initial begin
    logic [CW-1:0] saved_b, saved_m;
    logic [2:0] f3;
    logic [31:0] a, b, tgt, pc;

    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("rst_resolve", {31'd0, resolve_valid}, 32'd0);
    chk("rst_taken", {31'd0, branch_taken}, 32'd0);
    chk("rst_mis", {31'd0, mispredict_flag}, 32'd0);
    chk("rst_flush", {31'd0, flush_req}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    chk("rst_bcnt", {28'd0, branch_cnt}, 32'd0);
    chk("rst_mcnt", {28'd0, mispredict_cnt}, 32'd0);

    // BLT signed: -1 < 1 is taken, predicted not-taken.
    step(1'b1, 1'b0, mk_ir(BLT, OPCODE_BRANCH), 32'h100, 32'h180, 32'hFFFF_FFFF, 32'd1,
         1'b0, 32'd0, 1'b0, 1'b0);
    chk("t1_flush", {31'd0, flush_req}, 32'd1);
    chk("t1_redirect", redirect_pc, 32'h180);
    idle();
    // BLTU: 0xFFFFFFFF < 1 is false, prediction correct.
    step(1'b1, 1'b0, mk_ir(BLTU, OPCODE_BRANCH), 32'h104, 32'h180, 32'hFFFF_FFFF, 32'd1,
         1'b0, 32'd0, 1'b0, 1'b0);
    chk("t2_taken", {31'd0, branch_taken}, 32'd0);
    chk("t2_flush", {31'd0, flush_req}, 32'd0);
    chk("t2_bcnt", {28'd0, branch_cnt}, 32'd2);
    chk("t2_mcnt", {28'd0, mispredict_cnt}, 32'd1);
    // BEQ taken with wrong predicted target.
    step(1'b1, 1'b0, mk_ir(BEQ, OPCODE_BRANCH), 32'h108, 32'h200, 32'd5, 32'd5,
         1'b1, 32'h204, 1'b0, 1'b0);
    chk("t3_flush", {31'd0, flush_req}, 32'd1);
    chk("t3_redirect", redirect_pc, 32'h200);
    idle();
    // BNE at the top of the address space, actually not-taken: pc+4 wraps.
    step(1'b1, 1'b0, mk_ir(BNE, OPCODE_BRANCH), 32'hFFFF_FFFC, 32'h40, 32'd7, 32'd7,
         1'b1, 32'h40, 1'b0, 1'b0);
    chk("t4_redirect", redirect_pc, 32'h0);
    chk("t4_flush", {31'd0, flush_req}, 32'd1);
    saved_b = m_bcnt;
    step(1'b1, 1'b0, mk_ir(BEQ, OPCODE_BRANCH), 32'h0, 32'h80, 32'd1, 32'd1,
         1'b0, 32'd0, 1'b0, 1'b0);
    chk("t4_squash_resolve", {31'd0, resolve_valid}, 32'd0);
    chk("t4_squash_cnt", {28'd0, branch_cnt}, {28'd0, saved_b});

    // Illegal funct3 and a stalled BGE are neither resolved nor counted.
    saved_b = m_bcnt; saved_m = m_mcnt;
    step(1'b1, 1'b0, mk_ir(3'b010, OPCODE_BRANCH), 32'h300, 32'h380, 32'd1, 32'd2,
         1'b0, 32'd0, 1'b0, 1'b0);
    chk("t6_illegal_resolve", {31'd0, resolve_valid}, 32'd0);
    step(1'b1, 1'b1, mk_ir(BGE, OPCODE_BRANCH), 32'h304, 32'h380, 32'd9, 32'd2,
         1'b0, 32'd0, 1'b0, 1'b0);
    chk("t6_stall_resolve", {31'd0, resolve_valid}, 32'd0);
    chk("t6_stall_flush", {31'd0, flush_req}, 32'd0);
    chk("t6_bcnt", {28'd0, branch_cnt}, {28'd0, saved_b});
    chk("t6_mcnt", {28'd0, mispredict_cnt}, {28'd0, saved_m});

    // Saturation, then clear beating a same-cycle increment.
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b0, mk_ir(BNE, OPCODE_BRANCH), 32'h400, 32'h500, 32'd1, 32'd2,
           1'b0, 32'd0, 1'b0, 1'b0);
      idle();
    end
    chk("t5_bcnt_sat", {28'd0, branch_cnt}, 32'd15);
    chk("t5_mcnt_sat", {28'd0, mispredict_cnt}, 32'd15);
    step(1'b1, 1'b0, mk_ir(BNE, OPCODE_BRANCH), 32'h400, 32'h500, 32'd1, 32'd2,
         1'b0, 32'd0, 1'b1, 1'b0);
    chk("t5_bcnt_clr", {28'd0, branch_cnt}, 32'd0);
    chk("t5_mcnt_clr", {28'd0, mispredict_cnt}, 32'd0);
    idle();

    // Reset lands while flush_req is high.
    step(1'b1, 1'b0, mk_ir(BGEU, OPCODE_BRANCH), 32'h600, 32'h700, 32'd9, 32'd2,
         1'b0, 32'd0, 1'b0, 1'b0);
    chk("t6_pre_flush", {31'd0, flush_req}, 32'd1);
    step(1'b1, 1'b0, mk_ir(BEQ, OPCODE_BRANCH), 32'h604, 32'h700, 32'd3, 32'd3,
         1'b0, 32'd0, 1'b0, 1'b1);
    chk("t6_rst_flush", {31'd0, flush_req}, 32'd0);
    chk("t6_rst_resolve", {31'd0, resolve_valid}, 32'd0);
    chk("t6_rst_taken", {31'd0, branch_taken}, 32'd0);
    chk("t6_rst_redirect", redirect_pc, 32'd0);
    chk("t6_rst_bcnt", {28'd0, branch_cnt}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom();
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 4) == 0) begin
        a = 32'($urandom_range(0, 3)) - 32'd2;
        b = 32'($urandom_range(0, 3)) - 32'd2;
      end
      pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      tgt = $urandom() & 32'hFFFF_FFFC;
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
           mk_ir(f3, ($urandom_range(0, 9) == 0) ? 7'b0110011 : OPCODE_BRANCH),
           pc, tgt, a, b, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0) ? ($urandom() & 32'hFFFF_FFFC) : tgt,
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 96) == 0));
    end
    idle();
    idle();
    chk("drain_queue", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
